// File: rtl/core_pkg.sv
// Shared state encoding and default configuration for the core sequencer.
// Holds the widths and the halt opcode that the top-level parameters default to.
package core_pkg;
   localparam int PC_W_DEF    = 10;
   localparam int INSTR_W_DEF = 9;
   localparam int OP_W_DEF    = 4;
   localparam int CNT_W_DEF   = 16;
   localparam logic [3:0] HALT_OP_DEF = 4'b1101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2,
      HALT  = 2'd3
   } seq_state_t;
endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select: holds without commit, else absolute jump,
// taken relative branch, or sequential increment (all modulo 2^PC_W).
module pc_next #(
   parameter int PC_W = 10
) (
   input  logic [PC_W-1:0] i_pc,
   input  logic [PC_W-1:0] i_target,
   input  logic            i_abs_en,
   input  logic            i_rel_en,
   input  logic            i_alu_zero,
   input  logic            i_commit,
   output logic [PC_W-1:0] o_next_pc
);
   always_comb begin
      o_next_pc = i_pc;
      if (i_commit) begin
         if (i_abs_en) begin
            o_next_pc = i_target;
         end else if (i_rel_en && i_alu_zero) begin
            // Same-width add wraps exactly like a sign-extended offset would.
            o_next_pc = i_pc + i_target;
         end else begin
            o_next_pc = i_pc + PC_W'(1);
         end
      end
   end
endmodule

// File: rtl/core_sequencer.sv
// Program sequencer: IDLE/RUN/STALL/HALT control, PC update and saturating perf counters.
// Define CORE_SEQ_PERF_EN to implement InstrCt/StallCt; otherwise they are constant 0.
module core_sequencer
   import core_pkg::*;
#(
   parameter int               PC_W    = PC_W_DEF,
   parameter int               INSTR_W = INSTR_W_DEF,
   parameter int               OP_W    = OP_W_DEF,
   parameter int               CNT_W   = CNT_W_DEF,
   parameter logic [OP_W-1:0]  HALT_OP = OP_W'(HALT_OP_DEF)
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [INSTR_W-1:0] Instruction,
   input  logic               BranchAbsEn,
   input  logic               BranchRelEn,
   input  logic               AluZero,
   input  logic [PC_W-1:0]    Target,
   input  logic               MemOp,
   input  logic               MemBusy,
   output logic [PC_W-1:0]    ProgCtr,
   output logic               Commit,
   output logic               Ack,
   output logic [CNT_W-1:0]   CycleCt,
   output logic [CNT_W-1:0]   InstrCt,
   output logic [CNT_W-1:0]   StallCt
);
   seq_state_t       r_state;
   seq_state_t       w_state_nxt;
   logic [PC_W-1:0]  r_pc;
   logic [PC_W-1:0]  w_pc_nxt;
   logic             r_ack;
   logic [CNT_W-1:0] r_cycle_ct;
   logic             w_commit;
   logic             w_is_halt;
   logic             w_mem_stall;
   logic             w_active;
   logic             w_unused_instr;

   assign w_is_halt      = (Instruction[INSTR_W-1 -: OP_W] == HALT_OP);
   assign w_mem_stall    = MemOp && MemBusy;
   assign w_active       = (r_state == RUN) || (r_state == STALL);
   assign w_unused_instr = ^Instruction[INSTR_W-OP_W-1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      case (r_state)
         IDLE, HALT: begin
            if (Start) w_state_nxt = RUN;
         end
         RUN: begin
            if (Start)            w_state_nxt = RUN;
            else if (w_is_halt)   w_state_nxt = HALT;
            else if (w_mem_stall) w_state_nxt = STALL;
            else                  w_commit    = 1'b1;
         end
         STALL: begin
            if (Start) begin
               w_state_nxt = RUN;
            end else if (!MemBusy) begin
               w_commit    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // Reset discards whatever instruction is in flight this cycle.
      if (Reset) begin
         w_commit    = 1'b0;
         w_state_nxt = IDLE;
      end
   end

   pc_next #(.PC_W(PC_W)) u_pc_next (
      .i_pc       (r_pc),
      .i_target   (Target),
      .i_abs_en   (BranchAbsEn),
      .i_rel_en   (BranchRelEn),
      .i_alu_zero (AluZero),
      .i_commit   (w_commit),
      .o_next_pc  (w_pc_nxt)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_pc       <= '0;
         r_ack      <= 1'b0;
         r_cycle_ct <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= (w_state_nxt == HALT);
         if (Start) begin
            r_pc       <= '0;
            r_cycle_ct <= '0;
         end else begin
            r_pc <= w_pc_nxt;
            if (w_active && (r_cycle_ct != '1)) r_cycle_ct <= r_cycle_ct + CNT_W'(1);
         end
      end
   end

`ifdef CORE_SEQ_PERF_EN
   logic [CNT_W-1:0] r_instr_ct;
   logic [CNT_W-1:0] r_stall_ct;

   always_ff @(posedge Clk) begin
      if (Reset || Start) begin
         r_instr_ct <= '0;
         r_stall_ct <= '0;
      end else begin
         if (w_commit && (r_instr_ct != '1)) r_instr_ct <= r_instr_ct + CNT_W'(1);
         if ((r_state == STALL) && (r_stall_ct != '1)) r_stall_ct <= r_stall_ct + CNT_W'(1);
      end
   end

   assign InstrCt = r_instr_ct;
   assign StallCt = r_stall_ct;
`else
   assign InstrCt = '0;
   assign StallCt = '0;
`endif

   assign ProgCtr = r_pc;
   assign Commit  = w_commit;
   assign Ack     = r_ack;
   assign CycleCt = r_cycle_ct;
endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed scenarios with literal expectations, then random
// stimulus, all outputs compared each cycle against a program-level behavioural model.
module tb_core_sequencer;
   localparam int PC_W    = 10;
   localparam int INSTR_W = 9;
   localparam int CNT_W   = 16;
   localparam int PC_MOD  = 1 << PC_W;
   localparam int CMAX    = (1 << CNT_W) - 1;
   localparam int CMAX4   = 15;
   localparam logic [3:0] HALT_OPC = 4'b1101;

   logic               Clk = 1'b0;
   logic               Reset = 1'b0;
   logic               Start = 1'b0;
   logic [INSTR_W-1:0] Instruction = '0;
   logic               BranchAbsEn = 1'b0;
   logic               BranchRelEn = 1'b0;
   logic               AluZero = 1'b0;
   logic [PC_W-1:0]    Target = '0;
   logic               MemOp = 1'b0;
   logic               MemBusy = 1'b0;

   logic [PC_W-1:0]    ProgCtr;
   logic               Commit, Ack;
   logic [CNT_W-1:0]   CycleCt, InstrCt, StallCt;
   logic [PC_W-1:0]    s_ProgCtr;
   logic               s_Commit, s_Ack;
   logic [3:0]         s_CycleCt, s_InstrCt, s_StallCt;

   int n_checks = 0;
   int n_errors = 0;

   core_sequencer dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
      .BranchAbsEn(BranchAbsEn), .BranchRelEn(BranchRelEn), .AluZero(AluZero),
      .Target(Target), .MemOp(MemOp), .MemBusy(MemBusy),
      .ProgCtr(ProgCtr), .Commit(Commit), .Ack(Ack),
      .CycleCt(CycleCt), .InstrCt(InstrCt), .StallCt(StallCt)
   );

   core_sequencer #(.CNT_W(4)) dut_small (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
      .BranchAbsEn(BranchAbsEn), .BranchRelEn(BranchRelEn), .AluZero(AluZero),
      .Target(Target), .MemOp(MemOp), .MemBusy(MemBusy),
      .ProgCtr(s_ProgCtr), .Commit(s_Commit), .Ack(s_Ack),
      .CycleCt(s_CycleCt), .InstrCt(s_InstrCt), .StallCt(s_StallCt)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int perf(input int v);
`ifdef CORE_SEQ_PERF_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   // Model: program position, whether a memory access is being waited on, and done flag.
   int m_pc = 0, m_cyc = 0, m_ins = 0, m_stl = 0, m_cyc4 = 0;
   bit m_active = 0, m_wait = 0, m_done = 0, m_valid = 0;
   bit e_commit;

   always begin
      @(negedge Clk);
      #2;
      e_commit = !Reset && !Start && m_active &&
                 (m_wait ? !MemBusy : ((Instruction[8:5] != HALT_OPC) && !(MemOp && MemBusy)));
      if (m_valid) begin
         chk("commit",  32'(Commit),    32'(e_commit));
         chk("pc",      32'(ProgCtr),   32'(m_pc));
         chk("ack",     32'(Ack),       32'(m_done));
         chk("cycle",   32'(CycleCt),   32'(m_cyc));
         chk("instr",   32'(InstrCt),   32'(perf(m_ins)));
         chk("stall",   32'(StallCt),   32'(perf(m_stl)));
         chk("cycle4",  32'(s_CycleCt), 32'(m_cyc4));
      end
      if (Reset) begin
         m_valid = 1; m_active = 0; m_wait = 0; m_done = 0;
         m_pc = 0; m_cyc = 0; m_ins = 0; m_stl = 0; m_cyc4 = 0;
      end else if (Start) begin
         m_active = 1; m_wait = 0; m_done = 0;
         m_pc = 0; m_cyc = 0; m_ins = 0; m_stl = 0; m_cyc4 = 0;
      end else if (m_active) begin
         m_cyc  = (m_cyc  < CMAX)  ? m_cyc  + 1 : CMAX;
         m_cyc4 = (m_cyc4 < CMAX4) ? m_cyc4 + 1 : CMAX4;
         if (m_wait) m_stl = (m_stl < CMAX) ? m_stl + 1 : CMAX;
         if (e_commit) begin
            int off;
            m_ins = (m_ins < CMAX) ? m_ins + 1 : CMAX;
            m_wait = 0;
            off = int'(Target);
            if (off >= PC_MOD / 2) off = off - PC_MOD;
            if (BranchAbsEn)                 m_pc = int'(Target);
            else if (BranchRelEn && AluZero) m_pc = (m_pc + off + PC_MOD) % PC_MOD;
            else                             m_pc = (m_pc + 1) % PC_MOD;
         end else if (!m_wait) begin
            if (Instruction[8:5] == HALT_OPC) begin
               m_active = 0;
               m_done   = 1;
            end else begin
               m_wait = 1;
            end
         end
      end
   end

   task automatic drive_plain();
      Reset = 1'b0; Start = 1'b0; Instruction = '0;
      BranchAbsEn = 1'b0; BranchRelEn = 1'b0; AluZero = 1'b0;
      Target = '0; MemOp = 1'b0; MemBusy = 1'b0;
   endtask

   task automatic tick();
      @(negedge Clk);
      drive_plain();
   endtask

   // Start a program and return at the cycle whose PC is n, plain inputs driven.
   task automatic start_to(input int n);
      tick();
      Start = 1'b1;
      repeat (n + 1) tick();
   endtask

   initial begin
      // Reset, start, six plain instructions, halt.
      tick(); Reset = 1'b1; #3;
      chk("rst_commit", 32'(Commit), 32'(0));
      tick(); Start = 1'b1; #3;
      chk("rst_pc", 32'(ProgCtr), 32'(0));
      chk("rst_ack", 32'(Ack), 32'(0));
      chk("rst_cyc", 32'(CycleCt), 32'(0));
      chk("rst_ins", 32'(InstrCt), 32'(0));
      chk("rst_stl", 32'(StallCt), 32'(0));
      for (int i = 0; i < 6; i++) begin
         tick(); #3;
         chk("seq_pc", 32'(ProgCtr), 32'(i));
         chk("seq_commit", 32'(Commit), 32'(1));
      end
      tick(); Instruction = {HALT_OPC, 5'd0}; #3;
      chk("halt_pc", 32'(ProgCtr), 32'(6));
      chk("halt_commit", 32'(Commit), 32'(0));
      chk("halt_ack_early", 32'(Ack), 32'(0));
      tick(); #3;
      chk("halt_ack", 32'(Ack), 32'(1));
      chk("halt_pc_hold", 32'(ProgCtr), 32'(6));
      chk("halt_cyc", 32'(CycleCt), 32'(7));
      chk("halt_ins", 32'(InstrCt), 32'(perf(6)));

      // Relative branch taken / not taken, and absolute priority with wrap.
      start_to(4); BranchRelEn = 1'b1; Target = 10'h3FE; AluZero = 1'b1; #3;
      chk("rel_at4", 32'(ProgCtr), 32'(4));
      tick(); #3;
      chk("rel_taken", 32'(ProgCtr), 32'(2));
      tick(); tick(); BranchRelEn = 1'b1; Target = 10'h3FE; AluZero = 1'b0;
      tick(); #3;
      chk("rel_not_taken", 32'(ProgCtr), 32'(5));
      start_to(4); BranchAbsEn = 1'b1; BranchRelEn = 1'b1; AluZero = 1'b1; Target = 10'h3FE;
      tick(); #3;
      chk("abs_prio", 32'(ProgCtr), 32'(10'h3FE));
      tick(); #3;
      chk("pc_3ff", 32'(ProgCtr), 32'(10'h3FF));
      tick(); #3;
      chk("pc_wrap", 32'(ProgCtr), 32'(0));

      // Three busy cycles on a memory op at PC 3.
      start_to(3); MemOp = 1'b1; MemBusy = 1'b1; #3;
      chk("mem_c0", 32'(Commit), 32'(0));
      for (int i = 0; i < 2; i++) begin
         tick(); MemOp = 1'b1; MemBusy = 1'b1; #3;
         chk("mem_cbusy", 32'(Commit), 32'(0));
         chk("mem_pc", 32'(ProgCtr), 32'(3));
      end
      tick(); MemOp = 1'b1; #3;
      chk("mem_release", 32'(Commit), 32'(1));
      tick(); #3;
      chk("mem_pc4", 32'(ProgCtr), 32'(4));
      chk("mem_stl", 32'(StallCt), 32'(perf(3)));

      // Start while stalled, then Reset while running.
      start_to(2); MemOp = 1'b1; MemBusy = 1'b1;
      tick(); MemOp = 1'b1; MemBusy = 1'b1; Start = 1'b1; #3;
      chk("abort_commit", 32'(Commit), 32'(0));
      tick(); #3;
      chk("abort_pc", 32'(ProgCtr), 32'(0));
      chk("abort_cyc", 32'(CycleCt), 32'(0));
      chk("abort_stl", 32'(StallCt), 32'(0));
      chk("abort_run", 32'(Commit), 32'(1));
      tick(); Reset = 1'b1; #3;
      chk("rrun_commit", 32'(Commit), 32'(0));
      tick(); #3;
      chk("rrun_pc", 32'(ProgCtr), 32'(0));
      chk("rrun_cyc", 32'(CycleCt), 32'(0));
      chk("rrun_ins", 32'(InstrCt), 32'(0));

      // Small counter saturates while the wide one keeps counting.
      start_to(20); #3;
      chk("sat4", 32'(s_CycleCt), 32'(15));
      chk("cyc20", 32'(CycleCt), 32'(20));

      // Random traffic.
      repeat (3000) begin
         tick();
         Reset       = ($urandom_range(0, 199) == 0);
         Start       = ($urandom_range(0, 39) == 0);
         Instruction = INSTR_W'($urandom_range(0, 511));
         BranchAbsEn = ($urandom_range(0, 7) == 0);
         BranchRelEn = ($urandom_range(0, 3) == 0);
         AluZero     = 1'($urandom_range(0, 1));
         Target      = PC_W'($urandom_range(0, PC_MOD - 1));
         MemOp       = ($urandom_range(0, 3) == 0);
         MemBusy     = 1'($urandom_range(0, 1));
      end
      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter PC_W, default 10, program counter width.
REQ-002 Parameter INSTR_W, default 9, instruction width.
REQ-003 Parameter OP_W, default 4, opcode width; the opcode is Instruction[INSTR_W-1 -: OP_W].
REQ-004 Parameter CNT_W, default 16, width of the performance counters.
REQ-005 Parameter HALT_OP, default 4'b1101, opcode that ends the program.
REQ-006 Clk  input  1  clock; posedge only.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 Start  input  1  begin or restart the program at PC 0.
REQ-009 Instruction  input  INSTR_W  current instruction from the instruction ROM.
REQ-010 BranchAbsEn  input  1  absolute jump request.
REQ-011 BranchRelEn  input  1  relative branch request, taken only if AluZero.
REQ-012 AluZero  input  1  ALU zero flag.
REQ-013 Target  input  PC_W  jump address (absolute) or signed offset (relative).
REQ-014 MemOp  input  1  current instruction accesses data memory.
REQ-015 MemBusy  input  1  data memory not ready; stalls a MemOp.
REQ-016 ProgCtr  output  PC_W  program counter.
REQ-017 Commit  output  1  current instruction retires this cycle; downstream ANDs it with RegWrite and MemWrite.
REQ-018 Ack  output  1  program done, registered.
REQ-019 CycleCt  output  CNT_W  cycles spent in RUN or STALL.
REQ-020 InstrCt  output  CNT_W  retired instructions.
REQ-021 StallCt  output  CNT_W  cycles spent in STALL.

Function
REQ-022 The FSM states SHALL be IDLE, RUN, STALL and HALT.
REQ-023 IDLE: Commit=0, PC held; Start moves the FSM to RUN with PC<=0 and all counters cleared.
REQ-024 RUN: an instruction that is not HALT_OP and not (MemOp and MemBusy) SHALL assert Commit combinationally, and PC SHALL update on the next edge.
REQ-025 RUN with MemOp=1 and MemBusy=1: Commit=0, PC held, next state STALL.
REQ-026 STALL: Commit=0 while MemBusy=1; when MemBusy=0, Commit=1, PC updates and the next state is RUN.
REQ-027 A stall therefore costs exactly N extra cycles for N busy cycles.
REQ-028 RUN with opcode==HALT_OP: Commit=0, PC held, next state HALT; Ack=1 from the next cycle.
REQ-029 HALT: Ack=1 and PC held until Start or Reset.
REQ-030 Start in HALT SHALL behave as in IDLE and SHALL clear Ack.
REQ-031 Start in RUN or STALL SHALL abort and restart: Commit=0 that cycle, PC<=0, counters cleared, state RUN.
REQ-032 Next PC on commit:
- BranchAbsEn=1: Target.
- else BranchRelEn=1 and AluZero=1: PC + sign-extended Target, modulo 2^PC_W.
- otherwise: PC+1, modulo 2^PC_W.
REQ-033 BranchAbsEn SHALL take priority over BranchRelEn.
REQ-034 CycleCt SHALL increment every cycle in RUN or STALL, including the halting cycle.
REQ-035 InstrCt SHALL increment on Commit.
REQ-036 StallCt SHALL increment every cycle in STALL.
REQ-037 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-038 Branch inputs SHALL be ignored when Commit=0.

Reset
REQ-039 Reset SHALL be sampled on posedge Clk and override Start and all other inputs.
REQ-040 Reset values: state IDLE, ProgCtr=0, Ack=0, Commit=0, CycleCt=0, InstrCt=0, StallCt=0.
REQ-041 Reset asserted mid-RUN or mid-STALL SHALL discard the pending instruction with no Commit.

Configuration
REQ-042 Macro CORE_SEQ_PERF_EN defined: InstrCt and StallCt are implemented as specified.
REQ-043 Macro CORE_SEQ_PERF_EN undefined: InstrCt and StallCt are tied to 0 with no flops; CycleCt is always implemented.

Structure
REQ-044 Package core_pkg SHALL hold the seq_state_t enum, the HALT_OP default constant and the default widths.
REQ-045 Sub-module pc_next SHALL be combinational and compute the next PC from PC, Target, BranchAbsEn, BranchRelEn, AluZero and Commit.

Verification
REQ-046 Reset, then Start pulse, then six non-branch instructions, then HALT_OP:
- ProgCtr runs 0..6.
- Ack=1 from the cycle after PC 6.
- InstrCt=6, CycleCt=7.
REQ-047 At PC 4, BranchRelEn=1, Target=10'h3FE (-2):
- AluZero=1: next PC=2.
- AluZero=0: next PC=5.
- BranchAbsEn=1 together with rel: PC=Target.
REQ-048 MemOp=1 at PC 3 with MemBusy high for 3 cycles: Commit low for 3 cycles, PC stays 3, StallCt=3, then PC=4.
REQ-049 PC=10'h3FF, no branch: next PC=0. With CNT_W=4, 20 RUN cycles: CycleCt=15.
REQ-050 Start asserted in STALL, then Reset asserted in RUN:
- Start in STALL: PC=0, counters 0, state RUN, no Commit that cycle.
- Reset in RUN: outputs at REQ-040 values the next cycle.
REQ-051 Build with and without CORE_SEQ_PERF_EN:
- Undefined: InstrCt and StallCt stay 0.
- CycleCt identical in both builds.
